// File: rtl/imm_decode_stage_pkg.sv
// rtl/imm_decode_stage_pkg.sv - shared RV32I opcodes, format codes and opcode helper
package imm_decode_stage_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_S  = 3'd2,
        FMT_B  = 3'd3,
        FMT_U  = 3'd4,
        FMT_J  = 3'd5,
        FMT_SH = 3'd6
    } fmt_e;

    // True for the eleven base RV32I major opcodes
    function automatic logic is_base_opcode(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
            OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// rtl/imm_decode_stage_if.sv - input/output handshake bundle (optional out_illegal: IMM_ILLEGAL_DETECT_EN)
interface imm_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_pc_rel;
`ifdef IMM_ILLEGAL_DETECT_EN
    logic            out_illegal;
`endif

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
`ifdef IMM_ILLEGAL_DETECT_EN
        input  out_illegal,
`endif
        input  in_ready, out_valid, out_imm, out_fmt, out_pc_rel
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
`ifdef IMM_ILLEGAL_DETECT_EN
        output out_illegal,
`endif
        output in_ready, out_valid, out_imm, out_fmt, out_pc_rel
    );

endinterface

// File: rtl/imm_decode_stage_format_decode.sv
// rtl/imm_decode_stage_format_decode.sv - combinational inst -> {fmt, imm} (illegal flag: IMM_ILLEGAL_DETECT_EN)
module imm_format_decode
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [31:0]     inst,
    output fmt_e            fmt,
`ifdef IMM_ILLEGAL_DETECT_EN
    output logic            illegal,
`endif
    output logic [XLEN-1:0] imm
);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       bad;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

`ifdef IMM_ILLEGAL_DETECT_EN
    assign bad     = (inst[1:0] != 2'b11) || !is_base_opcode(opcode);
    assign illegal = bad;
`else
    assign bad = 1'b0;
`endif

    always_comb begin
        fmt = FMT_R;
        if (!bad) begin
            case (opcode)
                OPC_LOAD, OPC_JALR, OPC_SYSTEM: fmt = FMT_I;
                OPC_OP_IMM: fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SH : FMT_I;
                OPC_STORE:  fmt = FMT_S;
                OPC_BRANCH: fmt = FMT_B;
                OPC_LUI, OPC_AUIPC: fmt = FMT_U;
                OPC_JAL:    fmt = FMT_J;
                default:    fmt = FMT_R;
            endcase
        end
    end

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:  imm = sext32({{20{inst[31]}}, inst[31:20]});
            FMT_S:  imm = sext32({{20{inst[31]}}, inst[31:25], inst[11:7]});
            FMT_B:  imm = sext32({{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
            FMT_U:  imm = sext32({inst[31:12], 12'b0});
            FMT_J:  imm = sext32({{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
            // funct7 (arithmetic-shift select) is deliberately left out of the amount
            FMT_SH: imm = XLEN'(inst[SHAMT_W+19:20]);
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - registered immediate generator with 2-entry skid buffer (optional: IMM_ILLEGAL_DETECT_EN)
module imm_decode_stage
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    imm_decode_stage_if.slave  bus
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc_rel;
        fmt_e            fmt;
`ifdef IMM_ILLEGAL_DETECT_EN
        logic            illegal;
`endif
    } entry_t;

    fmt_e            dec_fmt;
    logic [XLEN-1:0] dec_imm;
    entry_t          new_entry;
    entry_t          head_q, head_d;
    entry_t          tail_q, tail_d;
    logic [1:0]      count_q, count_d;
    logic            push, pop;

`ifdef IMM_ILLEGAL_DETECT_EN
    logic            dec_illegal;
`endif

    imm_format_decode #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_dec (
        .inst    (bus.in_inst),
        .fmt     (dec_fmt),
`ifdef IMM_ILLEGAL_DETECT_EN
        .illegal (dec_illegal),
`endif
        .imm     (dec_imm)
    );

    always_comb begin
        new_entry        = '0;
        new_entry.imm    = dec_imm;
        new_entry.pc_rel = bus.in_pc + dec_imm;
        new_entry.fmt    = dec_fmt;
`ifdef IMM_ILLEGAL_DETECT_EN
        new_entry.illegal = dec_illegal;
`endif
    end

    assign bus.in_ready  = reset && (count_q < 2'd2);
    assign bus.out_valid = (count_q != 2'd0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    // head_q always drives the outputs, so an emptied buffer keeps showing the last entry
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        head_d  = new_entry;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_d = new_entry;
                    end else if (push) begin
                        tail_d  = new_entry;
                        count_d = 2'd2;
                    end else if (pop) begin
                        count_d = 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_d  = tail_q;
                        count_d = 2'd1;
                    end
                end
                default: count_d = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign bus.out_imm    = head_q.imm;
    assign bus.out_pc_rel = head_q.pc_rel;
    assign bus.out_fmt    = head_q.fmt;
`ifdef IMM_ILLEGAL_DETECT_EN
    assign bus.out_illegal = head_q.illegal;
`endif

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - directed self-checking bench for imm_decode_stage
module tb_imm_decode_stage;

    localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_B = 3'd3, F_U = 3'd4, F_J = 3'd5, F_SH = 3'd6;
    localparam logic [31:0] I_ADDI = 32'hFFF00093;
    localparam logic [31:0] I_BEQ  = 32'hFE000EE3;
    localparam logic [31:0] I_LUI  = 32'h123452B7;
    localparam logic [31:0] I_JAL  = 32'h001000EF;
    localparam logic [31:0] I_SRAI = 32'h4030D093;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic flush64;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    imm_decode_stage_if #(.XLEN(32)) bus32();
    imm_decode_stage_if #(.XLEN(64)) bus64();

    imm_decode_stage #(.XLEN(32), .SHAMT_W(5)) dut32 (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus32)
    );

    imm_decode_stage #(.XLEN(64), .SHAMT_W(6)) dut64 (
        .clk(clk), .reset(reset), .flush(flush64), .bus(bus64)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; flush64 = 1'b0;
        bus32.in_valid = 1'b0; bus32.in_inst = '0; bus32.in_pc = '0; bus32.out_ready = 1'b1;
        bus64.in_valid = 1'b0; bus64.in_inst = '0; bus64.in_pc = '0; bus64.out_ready = 1'b1;
        step(); step();
        total++; if (bus32.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", bus32.out_valid); else passed++;
        total++; if (bus32.in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", bus32.in_ready); else passed++;
        total++; if (bus32.out_imm !== 32'h0) $display("FAIL rst_imm got %h want 0", bus32.out_imm); else passed++;
        total++; if (bus32.out_fmt !== F_R) $display("FAIL rst_fmt got %0d want 0", bus32.out_fmt); else passed++;
        total++; if (bus32.out_pc_rel !== 32'h0) $display("FAIL rst_pc_rel got %h want 0", bus32.out_pc_rel); else passed++;
        reset = 1'b1;
        #1;
        total++; if (bus32.in_ready !== 1'b1) $display("FAIL rst_release_in_ready got %b want 1", bus32.in_ready); else passed++;
    endtask

    task automatic test_i_type();
        bus32.in_valid = 1'b1; bus32.in_inst = I_ADDI; bus32.in_pc = 32'h100;
        step();
        bus32.in_valid = 1'b0;
        total++; if (bus32.out_valid !== 1'b1) $display("FAIL addi_valid got %b want 1", bus32.out_valid); else passed++;
        total++; if (bus32.out_fmt !== F_I) $display("FAIL addi_fmt got %0d want %0d", bus32.out_fmt, F_I); else passed++;
        total++; if (bus32.out_imm !== 32'hFFFFFFFF) $display("FAIL addi_imm got %h want ffffffff", bus32.out_imm); else passed++;
        total++; if (bus32.out_pc_rel !== 32'h000000FF) $display("FAIL addi_pc_rel got %h want 000000ff", bus32.out_pc_rel); else passed++;
        step();
        total++; if (bus32.out_valid !== 1'b0) $display("FAIL addi_drained got %b want 0", bus32.out_valid); else passed++;
        total++; if (bus32.out_imm !== 32'hFFFFFFFF) $display("FAIL empty_hold_imm got %h want ffffffff", bus32.out_imm); else passed++;
    endtask

    task automatic test_b_type();
        bus32.in_valid = 1'b1; bus32.in_inst = I_BEQ; bus32.in_pc = 32'h200;
        step();
        bus32.in_valid = 1'b0;
        total++; if (bus32.out_fmt !== F_B) $display("FAIL beq_fmt got %0d want %0d", bus32.out_fmt, F_B); else passed++;
        total++; if (bus32.out_imm !== 32'hFFFFFFFC) $display("FAIL beq_imm got %h want fffffffc", bus32.out_imm); else passed++;
        total++; if (bus32.out_pc_rel !== 32'h000001FC) $display("FAIL beq_pc_rel got %h want 000001fc", bus32.out_pc_rel); else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        bus32.in_valid = 1'b1; bus32.in_inst = I_LUI; bus32.in_pc = 32'h300;
        step();
        total++; if (bus32.out_fmt !== F_U) $display("FAIL lui_fmt got %0d want %0d", bus32.out_fmt, F_U); else passed++;
        total++; if (bus32.out_imm !== 32'h12345000) $display("FAIL lui_imm got %h want 12345000", bus32.out_imm); else passed++;
        total++; if (bus32.out_pc_rel !== 32'h12345300) $display("FAIL lui_pc_rel got %h want 12345300", bus32.out_pc_rel); else passed++;
        bus32.in_inst = I_JAL; bus32.in_pc = 32'h304;
        step();
        bus32.in_valid = 1'b0;
        total++; if (bus32.out_valid !== 1'b1) $display("FAIL jal_valid got %b want 1", bus32.out_valid); else passed++;
        total++; if (bus32.out_fmt !== F_J) $display("FAIL jal_fmt got %0d want %0d", bus32.out_fmt, F_J); else passed++;
        total++; if (bus32.out_imm !== 32'h00000800) $display("FAIL jal_imm got %h want 00000800", bus32.out_imm); else passed++;
        total++; if (bus32.out_pc_rel !== 32'h00000B04) $display("FAIL jal_pc_rel got %h want 00000b04", bus32.out_pc_rel); else passed++;
        step();
        total++; if (bus32.out_valid !== 1'b0) $display("FAIL b2b_drained got %b want 0", bus32.out_valid); else passed++;
    endtask

    task automatic test_shamt();
        bus32.in_valid = 1'b1; bus32.in_inst = I_SRAI; bus32.in_pc = 32'h400;
        bus64.in_valid = 1'b1; bus64.in_inst = I_SRAI; bus64.in_pc = 64'h400;
        step();
        bus32.in_valid = 1'b0; bus64.in_valid = 1'b0;
        total++; if (bus32.out_fmt !== F_SH) $display("FAIL srai32_fmt got %0d want %0d", bus32.out_fmt, F_SH); else passed++;
        total++; if (bus32.out_imm !== 32'h3) $display("FAIL srai32_imm got %h want 00000003", bus32.out_imm); else passed++;
        total++; if (bus64.out_fmt !== F_SH) $display("FAIL srai64_fmt got %0d want %0d", bus64.out_fmt, F_SH); else passed++;
        total++; if (bus64.out_imm !== 64'h3) $display("FAIL srai64_imm got %h want 0000000000000003", bus64.out_imm); else passed++;
        total++; if (bus64.out_pc_rel !== 64'h403) $display("FAIL srai64_pc_rel got %h want 0000000000000403", bus64.out_pc_rel); else passed++;
        step();
        bus64.in_valid = 1'b1; bus64.in_inst = I_LUI; bus64.in_pc = 64'h0;
        bus64.in_inst[31] = 1'b1;
        step();
        bus64.in_valid = 1'b0;
        total++; if (bus64.out_imm !== 64'hFFFFFFFF92345000) $display("FAIL lui64_sext got %h want ffffffff92345000", bus64.out_imm); else passed++;
        step();
    endtask

    task automatic test_unknown_opcode();
        bus32.in_valid = 1'b1; bus32.in_inst = 32'hFFFFF000; bus32.in_pc = 32'h10;
        step();
        bus32.in_valid = 1'b0;
        total++; if (bus32.out_fmt !== F_R) $display("FAIL unk_fmt got %0d want 0", bus32.out_fmt); else passed++;
        total++; if (bus32.out_imm !== 32'h0) $display("FAIL unk_imm got %h want 0", bus32.out_imm); else passed++;
`ifdef IMM_ILLEGAL_DETECT_EN
        total++; if (bus32.out_illegal !== 1'b1) $display("FAIL unk_illegal got %b want 1", bus32.out_illegal); else passed++;
`endif
        step();
    endtask

    task automatic test_backpressure();
        bus32.out_ready = 1'b0;
        bus32.in_valid = 1'b1; bus32.in_inst = I_ADDI; bus32.in_pc = 32'h100;
        step();
        bus32.in_inst = I_BEQ; bus32.in_pc = 32'h200;
        total++; if (bus32.in_ready !== 1'b1) $display("FAIL bp_ready1 got %b want 1", bus32.in_ready); else passed++;
        step();
        bus32.in_inst = I_LUI; bus32.in_pc = 32'h300;
        total++; if (bus32.in_ready !== 1'b0) $display("FAIL bp_full_ready got %b want 0", bus32.in_ready); else passed++;
        step(); step();
        total++; if (bus32.out_imm !== 32'hFFFFFFFF) $display("FAIL bp_stall_imm got %h want ffffffff", bus32.out_imm); else passed++;
        total++; if (bus32.out_pc_rel !== 32'h000000FF) $display("FAIL bp_stall_pc_rel got %h want 000000ff", bus32.out_pc_rel); else passed++;
        total++; if (bus32.in_ready !== 1'b0) $display("FAIL bp_stall_ready got %b want 0", bus32.in_ready); else passed++;
        bus32.out_ready = 1'b1;
        step();
        total++; if (bus32.out_fmt !== F_B) $display("FAIL bp_drain2_fmt got %0d want %0d", bus32.out_fmt, F_B); else passed++;
        total++; if (bus32.in_ready !== 1'b1) $display("FAIL bp_slot_freed got %b want 1", bus32.in_ready); else passed++;
        step();
        bus32.in_valid = 1'b0;
        total++; if (bus32.out_imm !== 32'h12345000) $display("FAIL bp_drain3_imm got %h want 12345000", bus32.out_imm); else passed++;
        total++; if (bus32.out_valid !== 1'b1) $display("FAIL bp_drain3_valid got %b want 1", bus32.out_valid); else passed++;
        step();
        total++; if (bus32.out_valid !== 1'b0) $display("FAIL bp_empty got %b want 0", bus32.out_valid); else passed++;
    endtask

    task automatic test_flush();
        bus32.out_ready = 1'b0;
        bus32.in_valid = 1'b1; bus32.in_inst = I_ADDI; bus32.in_pc = 32'h100;
        step();
        bus32.in_inst = I_BEQ; bus32.in_pc = 32'h200;
        step();
        bus32.in_inst = I_JAL; bus32.in_pc = 32'h0;
        flush = 1'b1;
        step();
        flush = 1'b0; bus32.in_valid = 1'b0;
        total++; if (bus32.out_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", bus32.out_valid); else passed++;
        total++; if (bus32.in_ready !== 1'b1) $display("FAIL flush_ready got %b want 1", bus32.in_ready); else passed++;
        step();
        total++; if (bus32.out_valid !== 1'b0) $display("FAIL flush_push_dropped got %b want 0", bus32.out_valid); else passed++;
    endtask

    task automatic test_reset_mid();
        bus32.out_ready = 1'b0;
        bus32.in_valid = 1'b1; bus32.in_inst = I_LUI; bus32.in_pc = 32'h300;
        step();
        bus32.in_inst = I_JAL; bus32.in_pc = 32'h304;
        step();
        reset = 1'b0;
        step();
        total++; if (bus32.out_valid !== 1'b0) $display("FAIL mrst_valid got %b want 0", bus32.out_valid); else passed++;
        total++; if (bus32.in_ready !== 1'b0) $display("FAIL mrst_in_ready got %b want 0", bus32.in_ready); else passed++;
        total++; if (bus32.out_imm !== 32'h0) $display("FAIL mrst_imm got %h want 0", bus32.out_imm); else passed++;
        total++; if (bus32.out_pc_rel !== 32'h0) $display("FAIL mrst_pc_rel got %h want 0", bus32.out_pc_rel); else passed++;
        total++; if (bus32.out_fmt !== F_R) $display("FAIL mrst_fmt got %0d want 0", bus32.out_fmt); else passed++;
        reset = 1'b1; bus32.in_valid = 1'b0;
        #1;
        total++; if (bus32.in_ready !== 1'b1) $display("FAIL mrst_release_ready got %b want 1", bus32.in_ready); else passed++;
        step();
        total++; if (bus32.out_valid !== 1'b0) $display("FAIL mrst_count0 got %b want 0", bus32.out_valid); else passed++;
        bus32.out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_i_type();
        test_b_type();
        test_back_to_back();
        test_shamt();
        test_unknown_opcode();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Registered, parametrised immediate generator for the pipelined datapath. Sits between IF/ID and the ID/EX register.
- Decodes all RV32I immediate formats (I, S, B, U, J, shift-amount) and sign-extends to XLEN.
- Computes the PC-relative target (pc + imm) for branch, JAL and AUIPC.
- Buffers results in a 2-entry skid buffer with valid/ready handshakes on both sides.

Parameters:
- XLEN, 32, data/address width; legal values 32 or 64.
- SHAMT_W, 5, shift-amount width; 5 for XLEN=32, 6 for XLEN=64.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-low reset
- flush  input  1  drop all buffered entries (branch mispredict)
- in_valid  input  1  in_inst/in_pc valid
- in_ready  output  1  stage can accept an entry this cycle
- in_inst  input  32  raw instruction
- in_pc  input  XLEN  PC of in_inst
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer takes head entry this cycle
- out_imm  output  XLEN  sign/zero-extended immediate
- out_fmt  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, SH=6
- out_pc_rel  output  XLEN  in_pc + out_imm, wraps modulo 2^XLEN

Behaviour:
- Reset is synchronous and active-low.
  - While reset=0 at a rising edge: buffer count goes to 0, out_valid=0, out_imm=0, out_fmt=R, out_pc_rel=0.
  - in_ready=0 whenever reset=0; in_ready=1 from the first cycle after release.
  - Reset mid-operation discards all entries and overrides flush and push.
- Format decode (opcode = inst[6:0]):
  - LOAD, JALR, SYSTEM -> I.
  - OP_IMM -> I, except funct3 001/101 -> SH.
  - STORE -> S. BRANCH -> B. LUI, AUIPC -> U. JAL -> J.
  - All other opcodes -> R.
- Immediate construction:
  - I: sext(inst[31:20]).
  - S: sext({inst[31:25], inst[11:7]}).
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - U: sext({inst[31:12], 12'b0}); for XLEN=64, bit 31 extends into 63:32.
  - SH: zero-extended inst[SHAMT_W+19:20]; funct7 bits are excluded.
  - R: 0.
- out_pc_rel is always in_pc + imm, computed at push time. Consumers use it only for B, J and AUIPC.
- Handshake:
  - Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
  - in_ready = reset && (count < 2).
  - Latency is 1 cycle: an entry pushed at edge N appears on the outputs after edge N when the buffer was empty.
  - Order is FIFO. Head outputs are held stable while out_valid && !out_ready.
- Buffer boundary cases:
  - count=1 with simultaneous push and pop: count stays 1, and the new entry becomes head after the edge.
  - count=2: in_ready=0 and no push. A pop frees a slot, and in_ready rises the next cycle.
  - count=0: out_valid=0; out_imm/out_fmt/out_pc_rel hold their last values.
- Flush:
  - At an edge with flush=1, count goes to 0 and out_valid=0 next cycle.
  - A push in the same cycle is dropped; a pop in the same cycle is still counted as consumed.

Optional Feature:
- Macro IMM_ILLEGAL_DETECT_EN.
- Defined: adds output out_illegal (1 bit), buffered with the entry. It is 1 when inst[1:0] != 2'b11 or the opcode is not one of the 11 RV32I base opcodes. out_fmt=R and out_imm=0 in that case. out_illegal resets to 0.
- Undefined: the port is absent, and unknown opcodes silently decode as R with imm 0.

Decomposition:
- Shared opcodes include: add OP_IMM, LOAD, JALR, SYSTEM, LUI, AUIPC and OP alongside the existing STORE/JAL/BRANCH. Add FMT_R..FMT_SH format-code constants.
- Sub-module imm_format_decode: combinational, parameter XLEN. Maps inst to {fmt, imm}.
- The top level owns the adder, the 2-entry buffer, the handshake and flush logic.

Test Plan:
- Stimulus: addi x1,x0,-1 (0xFFF00093), pc 0x100. Response: fmt=I, imm=0xFFFFFFFF, pc_rel=0x000000FF, out_valid one cycle after push.
- Stimulus: beq x0,x0,-4 (0xFE000EE3), pc 0x200. Response: fmt=B, imm=0xFFFFFFFC, pc_rel=0x000001FC.
- Stimulus: lui x5,0x12345 (0x123452B7), then jal x1,+2048 (0x001000EF) back-to-back. Response: imm 0x12345000 (U) then 0x00000800 (J), in order.
- Stimulus: srai x1,x1,3 (0x4030D093). Response: fmt=SH, imm=0x00000003. Repeat with XLEN=64: imm=0x0000000000000003.
- Stimulus: out_ready=0, push 3 entries. Response: in_ready=0 after the second push and the third is held at the input. Raise out_ready: entries drain in order with outputs stable while stalled. Flush with 2 entries buffered: out_valid=0 next cycle.
- Stimulus: reset=0 for one edge while 2 entries are buffered and in_valid=1. Response: count=0, out_valid=0, outputs zero, in_ready=0 during reset and 1 the following cycle.
